// File: rtl/rfphoenix_fwft_fifo_pkg.sv
// Shared types and helpers for the rfPhoenix queue FIFOs.
package rfPhoenix_fifo_pkg;

    typedef enum logic [0:0] {
        FIFO_REG  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_t;

    // Count/pointer width: one extra bit over the index so full and empty differ.
    function automatic int fifo_cw(input int dep);
        return $clog2(dep) + 1;
    endfunction

endpackage

// File: rtl/rfphoenix_fwft_fifo_ram.sv
// DEP x WID distributed RAM: one synchronous write port, one asynchronous read port.
module rfphoenix_fifo_ram
    import rfPhoenix_fifo_pkg::*;
#(
    parameter int WID = 32,
    parameter int DEP = 16,
    parameter int AW  = fifo_cw(DEP) - 1
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [WID-1:0] wdata,
    input  logic [AW-1:0]  raddr,
    output logic [WID-1:0] rdata
);

    logic [WID-1:0] mem_r [DEP];

    // Array write; no reset so the storage maps onto LUT RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/rfphoenix_fwft_fifo.sv
// Synchronous FIFO with selectable show-ahead or registered read, programmable
// thresholds, synchronous flush and sticky overflow/underflow flags.
module rfphoenix_fwft_fifo
    import rfPhoenix_fifo_pkg::*;
#(
    parameter int WID  = 32,
    parameter int DEP  = 16,
    parameter int MODE = 1,
    parameter int CW   = fifo_cw(DEP)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           wr,
    input  logic [WID-1:0] di,
    input  logic           rd,
    output logic [WID-1:0] dout,
    output logic           v,
    output logic [CW-1:0]  cnt,
    input  logic [CW-1:0]  af_lvl,
    input  logic [CW-1:0]  ae_lvl,
    output logic           almost_full,
    output logic           almost_empty,
    output logic           full,
    output logic           empty,
    output logic           overflow,
    output logic           underflow,
    input  logic           clr_err
);

    localparam fifo_mode_t    MODE_SEL = (MODE == 1) ? FIFO_FWFT : FIFO_REG;
    localparam int            AW       = CW - 1;
    localparam logic [CW-1:0] PTR_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0]  wr_ptr_r, rd_ptr_r, cnt_r;
    logic [CW-1:0]  wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic           overflow_r, underflow_r;
    logic           ovf_nxt_s, unf_nxt_s;
    logic           full_s, empty_s, rd_ok_s, wr_ok_s, ram_we_s;
    logic [WID-1:0] ram_rdata_s;

    assign empty_s  = (cnt_r == {CW{1'b0}});
    assign full_s   = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[CW-1] != rd_ptr_r[CW-1]);
    assign rd_ok_s  = rd & ~empty_s;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_ok_s  = wr & (~full_s | rd_ok_s);
    assign ram_we_s = wr_ok_s & ~flush;

    rfphoenix_fifo_ram #(
        .WID (WID),
        .DEP (DEP),
        .AW  (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (wr_ptr_r[AW-1:0]),
        .wdata (di),
        .raddr (rd_ptr_r[AW-1:0]),
        .rdata (ram_rdata_s)
    );

    // Next pointers and sticky flags; flush overrides every request in its cycle.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        ovf_nxt_s    = overflow_r;
        unf_nxt_s    = underflow_r;
        if (flush) begin
            wr_ptr_nxt_s = {CW{1'b0}};
            rd_ptr_nxt_s = {CW{1'b0}};
            ovf_nxt_s    = 1'b0;
            unf_nxt_s    = 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (rd_ok_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            // A new error wins over clr_err in the same cycle.
            if (wr & ~wr_ok_s) begin
                ovf_nxt_s = 1'b1;
            end else if (clr_err) begin
                ovf_nxt_s = 1'b0;
            end else begin
                ovf_nxt_s = overflow_r;
            end
            if (rd & ~rd_ok_s) begin
                unf_nxt_s = 1'b1;
            end else if (clr_err) begin
                unf_nxt_s = 1'b0;
            end else begin
                unf_nxt_s = underflow_r;
            end
        end
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r    <= {CW{1'b0}};
            rd_ptr_r    <= {CW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            cnt_r       <= wr_ptr_nxt_s - rd_ptr_nxt_s;
            overflow_r  <= ovf_nxt_s;
            underflow_r <= unf_nxt_s;
        end
    end

    generate
        if (MODE_SEL == FIFO_FWFT) begin : g_fwft
            // Head shown directly; forced to zero while empty so stale RAM never leaks out.
            assign dout = empty_s ? {WID{1'b0}} : ram_rdata_s;
            assign v    = ~empty_s;
        end else begin : g_reg
            logic [WID-1:0] dout_r;
            logic           v_r;

            // Registered read port: capture the head on an accepted read.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dout_r <= {WID{1'b0}};
                    v_r    <= 1'b0;
                end else if (flush) begin
                    dout_r <= dout_r;
                    v_r    <= 1'b0;
                end else begin
                    if (rd_ok_s) begin
                        dout_r <= ram_rdata_s;
                    end
                    v_r <= rd_ok_s;
                end
            end

            assign dout = dout_r;
            assign v    = v_r;
        end
    endgenerate

    assign cnt          = cnt_r;
    assign full         = full_s;
    assign empty        = empty_s;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;
    assign almost_full  = (cnt_r >= af_lvl);
    assign almost_empty = (cnt_r <= ae_lvl);

endmodule

// File: tb/tb_rfphoenix_fwft_fifo.sv
// Bench for rfphoenix_fwft_fifo: a show-ahead and a registered-read instance share stimulus
// and are compared against a queue-based reference model.
module tb_rfphoenix_fwft_fifo;
    localparam int WID = 32;
    localparam int DEP = 16;
    localparam int CW  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, flush, wr, rd, clr_err;
    logic [WID-1:0] di;
    logic [CW-1:0]  af_lvl, ae_lvl;

    logic [WID-1:0] dout1, dout0;
    logic           v1, v0, af1, af0, ae1, ae0, full1, full0, empty1, empty0;
    logic           ovf1, ovf0, unf1, unf0;
    logic [CW-1:0]  cnt1, cnt0;

    rfphoenix_fwft_fifo #(.WID(WID), .DEP(DEP), .MODE(1)) dut_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr(wr), .di(di), .rd(rd),
        .dout(dout1), .v(v1), .cnt(cnt1), .af_lvl(af_lvl), .ae_lvl(ae_lvl),
        .almost_full(af1), .almost_empty(ae1), .full(full1), .empty(empty1),
        .overflow(ovf1), .underflow(unf1), .clr_err(clr_err)
    );

    rfphoenix_fwft_fifo #(.WID(WID), .DEP(DEP), .MODE(0)) dut_reg (
        .clk(clk), .rst(rst), .flush(flush), .wr(wr), .di(di), .rd(rd),
        .dout(dout0), .v(v0), .cnt(cnt0), .af_lvl(af_lvl), .ae_lvl(ae_lvl),
        .almost_full(af0), .almost_empty(ae0), .full(full0), .empty(empty0),
        .overflow(ovf0), .underflow(unf0), .clr_err(clr_err)
    );

    // Reference model
    logic [WID-1:0] q[$];
    logic           m_ovf, m_unf, m_v0;
    logic [WID-1:0] m_d0;
    int total = 0;
    int bad   = 0;

    function automatic logic [WID-1:0] head();
        if (q.size() != 0) return q[0];
        return '0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_v0 = 1'b0; m_d0 = '0;
    endtask

    // One clock cycle of stimulus; the model advances from its own pre-edge state.
    task automatic step(input logic w, input logic [WID-1:0] d, input logic r,
                        input logic f, input logic c);
        logic rd_ok, wr_ok;
        wr = w; di = d; rd = r; flush = f; clr_err = c;
        @(posedge clk);
        if (f) begin
            q.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_v0 = 1'b0;
        end else begin
            rd_ok = r && (q.size() != 0);
            wr_ok = w && ((q.size() < DEP) || rd_ok);
            if (rd_ok) m_d0 = q.pop_front();
            m_v0 = rd_ok;
            if (wr_ok) q.push_back(d);
            if (w && !wr_ok) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
            if (r && !rd_ok) m_unf = 1'b1; else if (c) m_unf = 1'b0;
        end
        #1;
        wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; af_lvl = '0; ae_lvl = '0;
        wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0; di = '0;
        model_reset();
        #3;
        total++; if (cnt1 !== 5'd0 || empty1 !== 1'b1 || full1 !== 1'b0) begin bad++;
            $display("FAIL reset_cnt: cnt=%0d empty=%b full=%b want 0/1/0", cnt1, empty1, full1); end
        total++; if (v1 !== 1'b0 || dout1 !== 32'd0 || v0 !== 1'b0 || dout0 !== 32'd0) begin bad++;
            $display("FAIL reset_out: v1=%b d1=%h v0=%b d0=%h want zeros", v1, dout1, v0, dout0); end
        total++; if (af1 !== 1'b1 || ovf1 !== 1'b0 || unf1 !== 1'b0) begin bad++;
            $display("FAIL reset_flags: af=%b ovf=%b unf=%b want 1/0/0", af1, ovf1, unf1); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        af_lvl = 5'd16; ae_lvl = 5'd0;
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        total++; if (unf1 !== 1'b1) begin bad++;
            $display("FAIL underflow_empty_rd: got %b want 1", unf1); end
        for (int i = 0; i < 6; i++) step(1'b1, 32'hC0DE_0000 + i, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        total++; if (cnt1 !== 5'd5 || dout0 !== 32'hC0DE_0000) begin bad++;
            $display("FAIL pre_reset: cnt=%0d d0=%h want 5/c0de0000", cnt1, dout0); end
        rst = 1'b0;
        #1;
        model_reset();
        total++; if (cnt1 !== 5'd0 || empty1 !== 1'b1 || v1 !== 1'b0 || dout1 !== 32'd0) begin bad++;
            $display("FAIL reset_mid: cnt=%0d empty=%b v=%b dout=%h want 0/1/0/0", cnt1, empty1, v1, dout1); end
        total++; if (unf1 !== 1'b0 || ovf1 !== 1'b0 || dout0 !== 32'd0 || cnt0 !== 5'd0) begin bad++;
            $display("FAIL reset_mid_flags: unf=%b ovf=%b d0=%h cnt0=%0d want 0/0/0/0", unf1, ovf1, dout0, cnt0); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEP; i++) step(1'b1, i, 1'b0, 1'b0, 1'b0);
        total++; if (full1 !== 1'b1 || cnt1 !== 5'd16) begin bad++;
            $display("FAIL fill_full: full=%b cnt=%0d want 1/16", full1, cnt1); end
        step(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
        total++; if (ovf1 !== 1'b1 || cnt1 !== 5'd16 || ovf0 !== 1'b1) begin bad++;
            $display("FAIL fill_overflow: ovf=%b cnt=%0d want 1/16", ovf1, cnt1); end
        for (int i = 0; i < DEP; i++) begin
            total++; if (dout1 !== i || v1 !== 1'b1) begin bad++;
                $display("FAIL drain_fwft[%0d]: dout=%h v=%b want %h/1", i, dout1, v1, i); end
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            total++; if (dout0 !== i || v0 !== 1'b1) begin bad++;
                $display("FAIL drain_reg[%0d]: dout=%h v=%b want %h/1", i, dout0, v0, i); end
        end
        total++; if (empty1 !== 1'b1 || v1 !== 1'b0) begin bad++;
            $display("FAIL drain_empty: empty=%b v=%b want 1/0", empty1, v1); end
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        total++; if (v0 !== 1'b0 || dout0 !== 32'd15) begin bad++;
            $display("FAIL reg_hold: v0=%b d0=%h want 0/f", v0, dout0); end
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_full_simul();
        logic [WID-1:0] last;
        for (int i = 0; i < DEP; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hAA, 1'b1, 1'b0, 1'b0);
        total++; if (cnt1 !== 5'd16 || ovf1 !== 1'b0 || full1 !== 1'b1) begin bad++;
            $display("FAIL full_simul: cnt=%0d ovf=%b full=%b want 16/0/1", cnt1, ovf1, full1); end
        last = '0;
        for (int i = 0; i < DEP; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            last = dout0;
        end
        total++; if (last !== 32'hAA || empty1 !== 1'b1) begin bad++;
            $display("FAIL full_simul_last: last=%h empty=%b want aa/1", last, empty1); end
    endtask

    task automatic test_empty_simul();
        step(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
        total++; if (unf1 !== 1'b1 || cnt1 !== 5'd1 || ovf1 !== 1'b0) begin bad++;
            $display("FAIL empty_simul: unf=%b cnt=%0d ovf=%b want 1/1/0", unf1, cnt1, ovf1); end
        total++; if (dout1 !== 32'h55 || v1 !== 1'b1 || v0 !== 1'b0) begin bad++;
            $display("FAIL empty_simul_out: dout=%h v=%b v0=%b want 55/1/0", dout1, v1, v0); end
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        total++; if (unf1 !== 1'b0 || dout0 !== 32'h55 || v0 !== 1'b1) begin bad++;
            $display("FAIL clr_unf: unf=%b d0=%h v0=%b want 0/55/1", unf1, dout0, v0); end
    endtask

    task automatic test_thresholds();
        af_lvl = 5'd12; ae_lvl = 5'd2;
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, k, 1'b0, 1'b0, 1'b0);
            total++; if (af1 !== (k >= 12) || af0 !== (k >= 12)) begin bad++;
                $display("FAIL almost_full[%0d]: got %b want %b", k, af1, (k >= 12)); end
        end
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            total++; if (ae1 !== ((12 - k) <= 2) || af1 !== 1'b0) begin bad++;
                $display("FAIL almost_empty[%0d]: ae=%b af=%b want %b/0", k, ae1, af1, ((12 - k) <= 2)); end
        end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_flush_wrap();
        for (int i = 0; i < 3; i++) step(1'b1, 100 + i, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 40; j++) begin
            step(1'b1, 103 + j, 1'b1, 1'b0, 1'b0);
            total++; if (dout0 !== 100 + j || dout1 !== 101 + j || cnt1 !== 5'd3) begin bad++;
                $display("FAIL wrap[%0d]: d0=%0d d1=%0d cnt=%0d want %0d/%0d/3", j, dout0, dout1, cnt1, 100 + j, 101 + j); end
        end
        for (int i = 0; i < 14; i++) step(1'b1, i, 1'b0, 1'b0, 1'b0);
        total++; if (ovf1 !== 1'b1 || cnt1 !== 5'd16) begin bad++;
            $display("FAIL wrap_ovf: ovf=%b cnt=%0d want 1/16", ovf1, cnt1); end
        step(1'b1, 32'h77, 1'b1, 1'b1, 1'b0);
        total++; if (cnt1 !== 5'd0 || empty1 !== 1'b1 || ovf1 !== 1'b0 || unf1 !== 1'b0 || v0 !== 1'b0) begin bad++;
            $display("FAIL flush: cnt=%0d empty=%b ovf=%b unf=%b v0=%b want 0/1/0/0/0", cnt1, empty1, ovf1, unf1, v0); end
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        total++; if (cnt1 !== 5'd0 || v1 !== 1'b0) begin bad++;
            $display("FAIL flush_no_add: cnt=%0d v=%b want 0/0", cnt1, v1); end
        for (int i = 0; i < 17; i++) step(1'b1, i, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h1, 1'b0, 1'b0, 1'b1);
        total++; if (ovf1 !== 1'b1) begin bad++;
            $display("FAIL clr_vs_new_err: ovf=%b want 1", ovf1); end
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        total++; if (ovf1 !== 1'b0 || cnt1 !== 5'd16) begin bad++;
            $display("FAIL clr_err: ovf=%b cnt=%0d want 0/16", ovf1, cnt1); end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if (n % 100 == 0) begin
                af_lvl = $urandom_range(0, 16);
                ae_lvl = $urandom_range(0, 16);
            end
            step($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5);
            total++; if (cnt1 !== CW'(q.size()) || cnt0 !== CW'(q.size())) begin bad++;
                $display("FAIL rnd_cnt[%0d]: cnt1=%0d cnt0=%0d want %0d", n, cnt1, cnt0, q.size()); end
            total++; if (full1 !== (q.size() == DEP) || empty1 !== (q.size() == 0) || v1 !== (q.size() != 0)) begin bad++;
                $display("FAIL rnd_status[%0d]: full=%b empty=%b v=%b size=%0d", n, full1, empty1, v1, q.size()); end
            total++; if (af1 !== (q.size() >= af_lvl) || ae1 !== (q.size() <= ae_lvl)) begin bad++;
                $display("FAIL rnd_thresh[%0d]: af=%b ae=%b size=%0d af_lvl=%0d ae_lvl=%0d", n, af1, ae1, q.size(), af_lvl, ae_lvl); end
            total++; if (ovf1 !== m_ovf || unf1 !== m_unf || ovf0 !== m_ovf || unf0 !== m_unf) begin bad++;
                $display("FAIL rnd_flags[%0d]: ovf=%b unf=%b want %b/%b", n, ovf1, unf1, m_ovf, m_unf); end
            if (q.size() != 0) begin
                total++; if (dout1 !== head()) begin bad++;
                    $display("FAIL rnd_head[%0d]: dout=%h want %h", n, dout1, head()); end
            end
            total++; if (v0 !== m_v0 || dout0 !== m_d0) begin bad++;
                $display("FAIL rnd_reg[%0d]: v0=%b d0=%h want %b/%h", n, v0, dout0, m_v0, m_d0); end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_fill();
        test_full_simul();
        test_empty_simul();
        test_thresholds();
        test_flush_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
